// File: rtl/mem_pkg.sv
// Shared types and default sizing for the mem_access load/store unit.
package mem_pkg;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_MEM_DEPTH = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/mem_access.sv
// Single-request load/store unit in front of a synchronous-read RAM.
// Optional macro MEM_ACCESS_RANGE_CHK_EN: reject addresses >= MEM_DEPTH with resp_err.
module mem_access
   import mem_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              ram_enable,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   if (!is_pow2(MEM_DEPTH)) begin : g_depth_chk
      $error("MEM_DEPTH must be a power of two");
   end

   state_e              state_q, state_d;
   logic                ram_enable_q, ram_enable_d;
   logic                ram_write_q, ram_write_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                resp_err_q, resp_err_d;
   logic                addr_err;

`ifdef MEM_ACCESS_RANGE_CHK_EN
   // Widened by one bit so a depth equal to 2**ADDR_W never overflows the compare.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
   assign addr_err = ({1'b0, req_addr} >= DEPTH_L);
`else
   assign addr_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      ram_enable_d = 1'b0;
      ram_write_d  = ram_write_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (addr_err) begin
                  state_d      = ST_RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d      = ST_ISSUE;
                  ram_enable_d = 1'b1;
                  ram_write_d  = req_write;
                  ram_addr_d   = req_addr;
                  ram_wdata_d  = req_wdata;
                  resp_err_d   = 1'b0;
               end
            end
         end
         ST_ISSUE: begin
            ram_write_d = 1'b0;
            if (ram_write_q) begin
               state_d      = ST_RESP;
               resp_rdata_d = '0;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         // RAM read data is valid in this cycle, one edge after the read was issued.
         ST_CAPTURE: begin
            resp_rdata_d = ram_rdata;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         ram_enable_q <= 1'b0;
         ram_write_q  <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ram_enable_q <= ram_enable_d;
         ram_write_q  <= ram_write_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign ram_enable = ram_enable_q;
   assign ram_write  = ram_write_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access with a behavioural RAM and a word-array reference model.
module tb_mem_access;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 64;
   localparam int IW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid, resp_ready, resp_err;
   logic [DW-1:0] resp_rdata;
   logic          ram_enable, ram_write;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];

   int n_cmp = 0;
   int n_bad = 0;
   int en_cnt = 0;

   always #5 clk = ~clk;

   mem_access #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ram_enable(ram_enable), .ram_write(ram_write), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Synchronous RAM: uses only the low address bits, read data one edge late.
   always @(posedge clk) begin
      if (ram_enable) begin
         if (ram_write) mem[ram_addr[IW-1:0]] <= ram_wdata;
         else           ram_rdata <= mem[ram_addr[IW-1:0]];
      end
   end

   always @(posedge clk) begin
      if (ram_enable) en_cnt <= en_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int hold, input bit junk);
      logic          exp_err;
      logic [DW-1:0] exp_rd;
      int            exp_lat, lat, en0;
      exp_err = 1'b0;
`ifdef MEM_ACCESS_RANGE_CHK_EN
      if (a >= DEPTH) exp_err = 1'b1;
`endif
      if (exp_err) begin
         exp_rd = '0; exp_lat = 1;
      end else if (wr) begin
         exp_rd = '0; exp_lat = 2;
         ref_mem[a % DEPTH] = d;
      end else begin
         exp_rd = ref_mem[a % DEPTH]; exp_lat = 3;
      end

      check("req_ready_idle", req_ready, 1);
      en0       = en_cnt;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk); #1;
      if (junk) begin
         req_write = 1'($urandom);
         req_addr  = AW'($urandom_range(0, DEPTH - 1));
         req_wdata = DW'($urandom);
      end else begin
         req_valid = 1'b0;
      end

      lat = 1;
      while (!resp_valid && lat < 8) begin
         check("req_ready_busy", req_ready, 0);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("req_ready_resp", req_ready, 0);

      for (int h = 0; h < hold; h++) begin
         check("hold_valid", resp_valid, 1);
         check("hold_rdata", resp_rdata, exp_rd);
         check("hold_ready", req_ready, 0);
         @(posedge clk); #1;
      end
      check("resp_rdata", resp_rdata, exp_rd);
      check("resp_err", resp_err, exp_err);

      resp_ready = 1'b1;
      req_valid  = 1'b0;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("post_valid", resp_valid, 0);
      check("post_idle", req_ready, 1);
      check("en_pulses", en_cnt - en0, exp_err ? 0 : 1);
   endtask

   initial begin
      int en0;
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_ram_enable", ram_enable, 0);
      check("rst_ram_write", ram_write, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_req_ready", req_ready, 1);

      // Fill every word, then read all back.
      for (int i = 0; i < DEPTH; i++) txn(1'b1, AW'(i), DW'(i), 0, 1'b0);
      for (int i = 0; i < DEPTH; i++) txn(1'b0, AW'(i), DW'(i), 0, 1'b0);

      txn(1'b1, 16'h0005, 16'hBEEF, 0, 1'b0);
      txn(1'b0, 16'h0005, 16'h0000, 0, 1'b0);
      txn(1'b0, 16'h0005, 16'h0000, 4, 1'b0);
      txn(1'b1, 16'h0011, 16'h5A5A, 2, 1'b1);
      txn(1'b0, 16'h0011, 16'h0000, 1, 1'b1);

      txn(1'b1, 16'h0040, 16'hA5A5, 0, 1'b0);
      txn(1'b0, 16'h0000, 16'h0000, 0, 1'b0);

      // Reset while the store is in its RAM-issue cycle.
      en0       = en_cnt;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0003;
      req_wdata = 16'h1234;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("issue_enable", ram_enable, 1);
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_enable", ram_enable, 0);
      check("mid_rst_valid", resp_valid, 0);
      check("mid_rst_rdata", resp_rdata, 0);
      check("mid_rst_err", resp_err, 0);
      check("mid_rst_write", ram_write, 0);
      check("mid_rst_addr", ram_addr, 0);
      check("mid_rst_wdata", ram_wdata, 0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_no_resp", resp_valid, 0);
      check("mid_rst_ready", req_ready, 1);
      check("mid_rst_pulses", en_cnt - en0, 0);
      txn(1'b0, 16'h0003, 16'h0000, 0, 1'b0);

      for (int k = 0; k < 150; k++) begin
         logic [AW-1:0] a;
         if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(DEPTH, 255));
         else                           a = AW'($urandom_range(0, DEPTH - 1));
         txn(1'($urandom), a, DW'($urandom), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
